// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter for the multi-ported register file.
// Grants up to NR_WRITE_PORTS distinct-address writes per cycle and presents them through one output register stage.
module regfile_wr_arbiter #(
    parameter int NR_REQ         = 4,
    parameter int NR_WRITE_PORTS = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic                                           enable_i,
    input  logic [NR_REQ-1:0]                              req_valid_i,
    output logic [NR_REQ-1:0]                              req_ready_o,
    input  logic [NR_REQ-1:0][ADDR_WIDTH-1:0]              req_addr_i,
    input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]              req_data_i,
    output logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]      waddr_o,
    output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]      wdata_o,
    output logic [NR_WRITE_PORTS-1:0]                      we_o,
    output logic [15:0]                                    conflict_cnt_o
);

    localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int CNT_W = $clog2(NR_WRITE_PORTS + 1);

    logic [PTR_W-1:0]                             rr_ptr_q, rr_ptr_d;
    logic [NR_WRITE_PORTS-1:0]                    we_q, we_d;
    logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]    waddr_q, waddr_d;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [15:0]                                  conflict_cnt_q, conflict_cnt_d;

    logic [NR_REQ-1:0] ready;
    logic [PTR_W:0]    scan_sum;
    logic [PTR_W-1:0]  idx;
    logic [PTR_W-1:0]  last_idx;
    logic [CNT_W-1:0]  n_assigned;
    logic              clash;
    logic              any_grant;
    logic              stall;

    // NOTE: every variable gets a default before the scan so no path leaves one unassigned (no latches).
    always_comb begin
        ready      = '0;
        we_d       = '0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        n_assigned = '0;
        last_idx   = rr_ptr_q;
        any_grant  = 1'b0;
        clash      = 1'b0;
        scan_sum   = '0;
        idx        = '0;

        for (int i = 0; i < NR_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (scan_sum >= (PTR_W+1)'(NR_REQ)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NR_REQ);
            end
            idx = scan_sum[PTR_W-1:0];

            if (req_valid_i[idx] && enable_i && rst_ni) begin
                if (req_addr_i[idx] == '0) begin
                    // Writes to r0 are discarded, so accept them without spending a port.
                    ready[idx] = 1'b1;
                end else begin
                    clash = 1'b0;
                    for (int k = 0; k < NR_WRITE_PORTS; k++) begin
                        if (we_d[k] && (waddr_d[k] == req_addr_i[idx])) begin
                            clash = 1'b1;
                        end
                    end
                    if (!clash && (n_assigned < CNT_W'(NR_WRITE_PORTS))) begin
                        for (int k = 0; k < NR_WRITE_PORTS; k++) begin
                            if (CNT_W'(k) == n_assigned) begin
                                we_d[k]    = 1'b1;
                                waddr_d[k] = req_addr_i[idx];
                                wdata_d[k] = req_data_i[idx];
                            end
                        end
                        n_assigned = n_assigned + CNT_W'(1);
                        ready[idx] = 1'b1;
                        last_idx   = idx;
                        any_grant  = 1'b1;
                    end
                end
            end
        end

        stall = |(req_valid_i & ~ready);

        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            rr_ptr_d = (last_idx == PTR_W'(NR_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
        end

        conflict_cnt_d = conflict_cnt_q;
        if (enable_i && stall && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q       <= '0;
            we_q           <= '0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            conflict_cnt_q <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            we_q           <= we_d;
            waddr_q        <= waddr_d;
            wdata_q        <= wdata_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign req_ready_o    = ready;
    assign we_o           = we_q;
    assign waddr_o        = waddr_q;
    assign wdata_o        = wdata_q;
    assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: hand-derived vector table with a scoreboard of expected
// register-file writes, plus a reset-while-writing sequence.
module tb_regfile_wr_arbiter;

    localparam int NR = 4;
    localparam int NP = 2;
    localparam int DW = 32;
    localparam int AW = 5;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  enable_i;
    logic [NR-1:0]         req_valid_i;
    logic [NR-1:0]         req_ready_o;
    logic [NR-1:0][AW-1:0] req_addr_i;
    logic [NR-1:0][DW-1:0] req_data_i;
    logic [NP-1:0][AW-1:0] waddr_o;
    logic [NP-1:0][DW-1:0] wdata_o;
    logic [NP-1:0]         we_o;
    logic [15:0]           conflict_cnt_o;

    regfile_wr_arbiter #(
        .NR_REQ(NR), .NR_WRITE_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o),
        .conflict_cnt_o(conflict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic                  en;
        logic [NR-1:0]         valid;
        logic [NR-1:0][AW-1:0] addr;
        logic [NR-1:0]         exp_ready;
        logic [NP-1:0]         exp_we;
        logic [NP-1:0][AW-1:0] exp_waddr;
        logic [NP-1:0][DW-1:0] exp_wdata;
        logic [15:0]           exp_cnt;
    } vec_t;

    typedef struct {
        int                    vec;
        logic [NP-1:0]         we;
        logic [NP-1:0][AW-1:0] waddr;
        logic [NP-1:0][DW-1:0] wdata;
        logic [15:0]           cnt;
    } out_t;

    vec_t tbl[15];
    out_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Data depends only on requester and address, so held requests keep stable data.
    function automatic logic [DW-1:0] d(input int r, input logic [AW-1:0] a);
        if (r == 2 && a == 5'd5) return 32'hDEADBEEF;
        return {8'hA0, 8'(r), 11'h0, a};
    endfunction

    task automatic drive(input vec_t t);
        enable_i    = t.en;
        req_valid_i = t.valid;
        req_addr_i  = t.addr;
        for (int r = 0; r < NR; r++) req_data_i[r] = d(r, t.addr[r]);
    endtask

    task automatic apply(input int v);
        vec_t t;
        out_t e;
        t = tbl[v];
        @(negedge clk_i);
        drive(t);
        #1;
        check($sformatf("v%0d ready", v), 64'(req_ready_o), 64'(t.exp_ready));
        e.vec = v; e.we = t.exp_we; e.waddr = t.exp_waddr; e.wdata = t.exp_wdata; e.cnt = t.exp_cnt;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        if (sb.size() == 0) begin
            check($sformatf("v%0d scoreboard empty", v), 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d we", e.vec), 64'(we_o), 64'(e.we));
            check($sformatf("v%0d waddr", e.vec), 64'(waddr_o), 64'(e.waddr));
            check($sformatf("v%0d wdata", e.vec), 64'(wdata_o), 64'(e.wdata));
            check($sformatf("v%0d conflict_cnt", e.vec), 64'(conflict_cnt_o), 64'(e.cnt));
            check($sformatf("v%0d duplicate port addr", e.vec),
                  64'(we_o == 2'b11 && waddr_o[0] == waddr_o[1]), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected values worked out by hand, tracking rr_ptr across rows.
        tbl[0]  = '{1'b1, 4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, 4'b0100, 2'b01,
                    {5'd0, 5'd5}, {32'h0, d(2, 5)}, 16'd0};                     // single write, rr->3
        tbl[1]  = '{1'b1, 4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 4'b1001, 2'b11,
                    {5'd10, 5'd13}, {d(0, 10), d(3, 13)}, 16'd1};               // wrap: req3, req0; rr->1
        tbl[2]  = '{1'b1, 4'b0110, {5'd0, 5'd12, 5'd11, 5'd0}, 4'b0110, 2'b11,
                    {5'd12, 5'd11}, {d(2, 12), d(1, 11)}, 16'd1};               // rr->3
        tbl[3]  = '{1'b1, 4'b1000, {5'd20, 5'd0, 5'd0, 5'd0}, 4'b1000, 2'b01,
                    {5'd12, 5'd20}, {d(2, 12), d(3, 20)}, 16'd1};               // port1 holds, rr->0
        tbl[4]  = '{1'b1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0011, 2'b11,
                    {5'd2, 5'd1}, {d(1, 2), d(0, 1)}, 16'd2};                   // exhaustion, rr->2
        tbl[5]  = '{1'b1, 4'b1100, {5'd4, 5'd3, 5'd0, 5'd0}, 4'b1100, 2'b11,
                    {5'd4, 5'd3}, {d(3, 4), d(2, 3)}, 16'd2};                   // rr->0
        tbl[6]  = '{1'b1, 4'b0111, {5'd0, 5'd9, 5'd7, 5'd7}, 4'b0101, 2'b11,
                    {5'd9, 5'd7}, {d(2, 9), d(0, 7)}, 16'd3};                   // collision, rr->3
        tbl[7]  = '{1'b1, 4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, 4'b0010, 2'b01,
                    {5'd9, 5'd7}, {d(2, 9), d(1, 7)}, 16'd3};                   // retry, rr->2
        tbl[8]  = '{1'b1, 4'b1010, {5'd4, 5'd0, 5'd0, 5'd0}, 4'b1010, 2'b01,
                    {5'd9, 5'd4}, {d(2, 9), d(3, 4)}, 16'd3};                   // r0 + addr4, rr->0
        tbl[9]  = '{1'b1, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 2'b00,
                    {5'd9, 5'd4}, {d(2, 9), d(3, 4)}, 16'd3};                   // idle, outputs hold
        for (int i = 10; i < 13; i++)
            tbl[i] = '{1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 2'b00,
                       {5'd9, 5'd4}, {d(2, 9), d(3, 4)}, 16'd3};                // disabled
        tbl[13] = '{1'b1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0011, 2'b11,
                    {5'd2, 5'd1}, {d(1, 2), d(0, 1)}, 16'd4};                   // rr held at 0
        tbl[14] = '{1'b1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0011, 2'b11,
                    {5'd2, 5'd1}, {d(1, 2), d(0, 1)}, 16'd1};                   // after reset, rr=0

        rst_ni = 1'b0;
        drive(tbl[4]);
        #12;
        check("reset ready", 64'(req_ready_o), 64'd0);
        check("reset we", 64'(we_o), 64'd0);
        check("reset waddr", 64'(waddr_o), 64'd0);
        check("reset wdata", 64'(wdata_o), 64'd0);
        check("reset conflict_cnt", 64'(conflict_cnt_o), 64'd0);
        req_valid_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int v = 0; v < 14; v++) apply(v);

        // Reset asserted mid-cycle while both ports are writing.
        check("pre-reset we", 64'(we_o), 64'b11);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async reset we", 64'(we_o), 64'd0);
        check("async reset conflict_cnt", 64'(conflict_cnt_o), 64'd0);
        check("async reset waddr", 64'(waddr_o), 64'd0);
        check("in-reset ready", 64'(req_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        check("held reset we", 64'(we_o), 64'd0);
        req_valid_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply(14);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
